mem_dma: RTL

Word-copy DMA engine for the picorv32 native memory bus. It has two bus ports. A responder port carries the register file, decoded the same way as the other peripherals. An initiator port issues read/write beats on the native valid/ready protocol. Software programs source, destination and word count, then starts the copy. The engine copies one 32-bit word at a time and raises a sticky done flag and an interrupt when finished.

---
 rtl/dma_pkg.sv | 14 +
 rtl/mem_dma.sv | 113 +++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, register offsets and CTRL bit positions for mem_dma
package dma_pkg;
  typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP} state_t;
  localparam logic [2:0] REG_SRC = 3'd0;
  localparam logic [2:0] REG_DST = 3'd1;
  localparam logic [2:0] REG_LEN = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_BUSY = 0;
  localparam int CTRL_DONE = 1;
  localparam int CTRL_ABORTED = 2;
  localparam int CTRL_IE = 3;
endpackage

// File: rtl/mem_dma.sv
// mem_dma: word-copy DMA engine with native-bus register port and initiator port
module mem_dma
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_instr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        irq
);
  state_t state, state_n;
  logic [31:0] src, dst, cur_src, cur_dst, rbuf, ctrl_rd;
  logic [15:0] len, remaining;
  logic ie, done, aborted, abort_pend;
  logic wr, start, abort, busy;
  logic [2:0] sel;
  logic unused_ok;
  assign unused_ok = ^{mem_instr, mem_addr[31:5], mem_addr[1:0]};
  assign sel = mem_addr[4:2];
  assign wr = mem_valid & enable & |mem_wstrb;
  assign start = wr && sel == REG_CTRL && mem_wdata[CTRL_START];
  assign abort = wr && sel == REG_CTRL && mem_wdata[CTRL_ABORT];
  assign busy = state != IDLE;
  assign m_valid = state == RD || state == WR;
  assign m_instr = 1'b0;
  assign m_addr = state == WR ? cur_dst : cur_src;
  assign m_wdata = rbuf;
  assign m_wstrb = state == WR ? 4'hF : 4'h0;
  assign irq = done & ie;
  // register readback, CTRL status assembled from live engine state
  always_comb begin
    ctrl_rd = {remaining, 16'h0};
    ctrl_rd[CTRL_BUSY] = busy;
    ctrl_rd[CTRL_DONE] = done;
    ctrl_rd[CTRL_ABORTED] = aborted;
    ctrl_rd[CTRL_IE] = ie;
    mem_rdata = sel == REG_SRC ? src :
                sel == REG_DST ? dst :
                sel == REG_LEN ? {16'h0, len} :
                sel == REG_CTRL ? ctrl_rd : 32'h0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state: beats never drop before ready, pending abort acts only in the gaps
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start && len != 16'd0 ? RD : IDLE;
      RD: state_n = m_ready ? RGAP : RD;
      RGAP: state_n = abort_pend ? IDLE : WR;
      WR: state_n = !m_ready ? WR : remaining == 16'd1 ? IDLE : WGAP;
      WGAP: state_n = abort_pend ? IDLE : RD;
      default: state_n = IDLE;
    endcase
  end
  // register file, working pointers and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      remaining <= '0;
      rbuf <= '0;
      ie <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      mem_ready <= mem_valid & enable;
      if (wr && sel == REG_CTRL) ie <= mem_wdata[CTRL_IE];
      if (wr && !busy && sel == REG_SRC) src <= {mem_wdata[31:2], 2'b00};
      if (wr && !busy && sel == REG_DST) dst <= {mem_wdata[31:2], 2'b00};
      if (wr && !busy && sel == REG_LEN) len <= mem_wdata[15:0];
      if (start && !busy) begin
        cur_src <= src;
        cur_dst <= dst;
        remaining <= len;
        done <= len == 16'd0;
        aborted <= 1'b0;
      end
      if (state == RD && m_ready) begin
        rbuf <= m_rdata;
        cur_src <= cur_src + 32'd4;
      end
      if (state == WR && m_ready) begin
        cur_dst <= cur_dst + 32'd4;
        remaining <= remaining - 16'd1;
        if (remaining == 16'd1) done <= 1'b1;
      end
      if ((state == RGAP || state == WGAP) && abort_pend) aborted <= 1'b1;
      abort_pend <= state_n == IDLE ? 1'b0 : abort && busy ? 1'b1 : abort_pend;
    end
  end
endmodule
